// File: rtl/draw_pkg.sv
// Shared screen geometry, pixel field widths, sequencer state codes and the pixel record
// used by the draw sequencer and its pixel mux.
package draw_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int C_W      = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef struct packed {
    logic           plot;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
  } pixel_t;

  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
  endfunction
endpackage

// File: rtl/draw_sequencer_if.sv
// Bundle between the draw sequencer, its drawing clients and the VGA adapter.
// The slave modport is the sequencer's view; master is the surrounding system's view.
interface draw_sequencer_if #(parameter int NUM_CLIENTS = 4);
  import draw_pkg::*;

  logic                           frame_go;
  logic [NUM_CLIENTS-1:0]         skip_mask;
  logic [NUM_CLIENTS-1:0]         client_en;
  logic [NUM_CLIENTS-1:0]         client_finish;
  logic [NUM_CLIENTS-1:0]         client_plot;
  logic [NUM_CLIENTS*X_W-1:0]     client_x;
  logic [NUM_CLIENTS*Y_W-1:0]     client_y;
  logic [NUM_CLIENTS*C_W-1:0]     client_colour;
  logic [X_W-1:0]                 vga_x;
  logic [Y_W-1:0]                 vga_y;
  logic [C_W-1:0]                 vga_colour;
  logic                           vga_plot;
  logic                           busy;
  logic                           pass_done;
  logic [NUM_CLIENTS-1:0]         timeout_err;

  modport slave (
    input  frame_go, skip_mask, client_finish, client_plot, client_x, client_y, client_colour,
    output client_en, vga_x, vga_y, vga_colour, vga_plot, busy, pass_done, timeout_err
  );

  modport master (
    output frame_go, skip_mask, client_finish, client_plot, client_x, client_y, client_colour,
    input  client_en, vga_x, vga_y, vga_colour, vga_plot, busy, pass_done, timeout_err
  );
endinterface

// File: rtl/draw_pixel_mux.sv
// Selects the active client's pixel and registers it for the VGA adapter (1-cycle latency).
// DRAW_SEQ_CLIP_EN suppresses plot for off-screen pixels; data fields still load.
module draw_pixel_mux
  import draw_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int SEL_W       = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [SEL_W-1:0]           i_sel,
  input  logic                       i_active,
  input  logic [NUM_CLIENTS-1:0]     i_plot,
  input  logic [NUM_CLIENTS*X_W-1:0] i_x,
  input  logic [NUM_CLIENTS*Y_W-1:0] i_y,
  input  logic [NUM_CLIENTS*C_W-1:0] i_colour,
  output pixel_t                     o_pix
);
  pixel_t w_pick;
  logic   w_visible;
  pixel_t r_pix;

  always_comb begin
    w_pick.plot   = i_plot[i_sel];
    w_pick.x      = i_x[int'(i_sel)*X_W +: X_W];
    w_pick.y      = i_y[int'(i_sel)*Y_W +: Y_W];
    w_pick.colour = i_colour[int'(i_sel)*C_W +: C_W];
  end

`ifdef DRAW_SEQ_CLIP_EN
  assign w_visible = on_screen(w_pick.x, w_pick.y);
`else
  assign w_visible = 1'b1;
`endif

  // Outside START/RUN the last coordinates are held so the adapter bus stays quiet.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pix <= '0;
    end else if (i_active) begin
      r_pix <= {w_pick.plot & w_visible, w_pick.x, w_pick.y, w_pick.colour};
    end else begin
      r_pix.plot <= 1'b0;
    end
  end

  assign o_pix = r_pix;
endmodule

// File: rtl/draw_sequencer.sv
// Runs one redraw pass per frame_go, starting each unskipped client in index order with a
// watchdog per client; pixels reach the VGA bus 1 cycle late. Clipping via DRAW_SEQ_CLIP_EN.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int TIMEOUT_CYCLES = 32768
) (
  input  logic             clock,
  input  logic             reset,
  draw_sequencer_if.slave  bus
);
  localparam int SEL_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]             r_state;
  logic [SEL_W-1:0]       r_sel;
  logic [NUM_CLIENTS-1:0] r_skip;
  logic [WD_W-1:0]        r_wdog;
  logic [NUM_CLIENTS-1:0] r_timeout_err;

  logic                   w_first_vld;
  logic [SEL_W-1:0]       w_first_idx;
  logic                   w_next_vld;
  logic [SEL_W-1:0]       w_next_idx;
  logic                   w_finish;
  logic                   w_active;
  pixel_t                 w_pix;

  // Descending scans so the lowest qualifying index is the one left standing.
  always_comb begin
    w_first_vld = 1'b0;
    w_first_idx = '0;
    w_next_vld  = 1'b0;
    w_next_idx  = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (!bus.skip_mask[i]) begin
        w_first_vld = 1'b1;
        w_first_idx = SEL_W'(i);
      end
      if (!r_skip[i] && (i > int'(r_sel))) begin
        w_next_vld = 1'b1;
        w_next_idx = SEL_W'(i);
      end
    end
  end

  assign w_finish = bus.client_finish[r_sel];
  assign w_active = (r_state == S_START) || (r_state == S_RUN);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_sel         <= '0;
      r_skip        <= '0;
      r_wdog        <= '0;
      r_timeout_err <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.frame_go) begin
            r_skip        <= bus.skip_mask;
            r_timeout_err <= '0;
            r_sel         <= w_first_idx;
            r_state       <= w_first_vld ? S_START : S_DONE;
          end
        end
        S_START: begin
          r_wdog  <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          // A finish landing on the last watchdog cycle still counts as a clean exit.
          if (w_finish) begin
            r_state <= S_NEXT;
          end else if (r_wdog == WD_LAST) begin
            r_state              <= S_NEXT;
            r_timeout_err[r_sel] <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_NEXT: begin
          if (w_next_vld) begin
            r_sel   <= w_next_idx;
            r_state <= S_START;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.client_en   = (r_state == S_START) ? (NUM_CLIENTS'(1) << r_sel) : '0;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.pass_done   = (r_state == S_DONE);
  assign bus.timeout_err = r_timeout_err;

  draw_pixel_mux #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .SEL_W       (SEL_W)
  ) u_pixel_mux (
    .clock    (clock),
    .reset    (reset),
    .i_sel    (r_sel),
    .i_active (w_active),
    .i_plot   (bus.client_plot),
    .i_x      (bus.client_x),
    .i_y      (bus.client_y),
    .i_colour (bus.client_colour),
    .o_pix    (w_pix)
  );

  assign bus.vga_plot   = w_pix.plot;
  assign bus.vga_x      = w_pix.x;
  assign bus.vga_y      = w_pix.y;
  assign bus.vga_colour = w_pix.colour;
endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: model clients plot scripted pixels, a monitor logs
// EN pulses, VGA pixels and pass_done by cycle, and each pass is compared with expectations.
module tb_draw_sequencer;
  import draw_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  draw_sequencer_if #(.NUM_CLIENTS(N)) bus ();

  draw_sequencer #(.NUM_CLIENTS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int c, input logic [7:0] x, input logic [6:0] y,
                                     input logic [2:0] col);
    return {32'(c), x, 1'b0, y, 5'b0, col, 8'h00};
  endfunction

  function automatic bit visible(input logic [7:0] x, input logic [6:0] y);
`ifdef DRAW_SEQ_CLIP_EN
    return (x < 8'd160) && (y < 7'd120);
`else
    return (x == x) && (y == y);
`endif
  endfunction

  // Model clients: len[i] pixels after EN, finish with the last one; len 0 hangs.
  int         len   [N];
  bit         stray [N];
  int         k     [N];
  logic [7:0] px_x  [N][16];
  logic [6:0] px_y  [N][16];
  logic [2:0] px_c  [N][16];

  task automatic default_pixels();
    for (int i = 0; i < N; i++) begin
      len[i]   = 3;
      stray[i] = 1'b0;
      for (int j = 0; j < 16; j++) begin
        px_x[i][j] = 8'(10 * i + j + 1);
        px_y[i][j] = 7'(3 * i + j);
        px_c[i][j] = 3'(i + j + 1);
      end
    end
  endtask

  task automatic drive_clients();
    bit act;
    for (int i = 0; i < N; i++) begin
      act = (k[i] >= 0) && (k[i] < len[i]);
      bus.client_plot[i]   = act || stray[i];
      bus.client_finish[i] = (act && (k[i] == len[i] - 1)) || stray[i];
      bus.client_x[8*i +: 8]      = act ? px_x[i][k[i]] : (stray[i] ? 8'd5 : 8'd0);
      bus.client_y[7*i +: 7]      = act ? px_y[i][k[i]] : (stray[i] ? 7'd5 : 7'd0);
      bus.client_colour[3*i +: 3] = act ? px_c[i][k[i]] : (stray[i] ? 3'b111 : 3'b000);
    end
  endtask

  initial begin
    logic [N-1:0] en_s;
    for (int i = 0; i < N; i++) k[i] = -1;
    default_pixels();
    drive_clients();
    forever begin
      @(negedge clock);
      en_s = bus.client_en;
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (reset) k[i] = -1;
        else if (en_s[i]) k[i] = 0;
        else if (k[i] >= 0) k[i] = (len[i] == 0 || k[i] + 1 < len[i]) ? k[i] + 1 : -1;
      end
      drive_clients();
    end
  end

  logic [63:0] pix_q [$];
  logic [63:0] en_q  [$];
  int          done_q[$];

  initial begin
    forever begin
      @(negedge clock);
      if (bus.vga_plot) pix_q.push_back(pk(cyc, bus.vga_x, bus.vga_y, bus.vga_colour));
      for (int i = 0; i < N; i++)
        if (bus.client_en[i]) en_q.push_back({32'(i), 32'(cyc)});
      if (bus.pass_done) done_q.push_back(cyc);
    end
  end

  task automatic run_pass(input string tag, input logic [N-1:0] mask, input bit go_mid);
    int          a, t, r, w, e_done;
    logic [63:0] ep[$];
    logic [63:0] ee[$];
    logic [N-1:0] e_err;
    pix_q.delete(); en_q.delete(); done_q.delete();
    @(posedge clock);
    #1;
    bus.skip_mask = mask;
    bus.frame_go  = 1'b1;
    a = cyc;
    check({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
    t = a + 1;
    e_err = '0;
    for (int i = 0; i < N; i++) begin
      if (!mask[i]) begin
        r = (len[i] == 0 || len[i] > TO) ? TO : len[i];
        if (len[i] == 0 || len[i] > TO) e_err[i] = 1'b1;
        ee.push_back({32'(i), 32'(t)});
        for (int j = 0; j < r && j < len[i]; j++)
          if (visible(px_x[i][j], px_y[i][j]))
            ep.push_back(pk(t + 2 + j, px_x[i][j], px_y[i][j], px_c[i][j]));
        t += r + 2;
      end
    end
    e_done = t;
    @(posedge clock);
    #1;
    bus.frame_go = 1'b0;
    check({tag, "_busy_run"}, 64'(bus.busy), 64'd1);
    check({tag, "_err_clear"}, 64'(bus.timeout_err), 64'd0);
    w = 0;
    while (done_q.size() == 0 && w < 400) begin
      @(negedge clock);
      w++;
      bus.frame_go = go_mid && (w == 6);
    end
    bus.frame_go = 1'b0;
    repeat (6) @(negedge clock);
    check({tag, "_done_cnt"}, 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) check({tag, "_done_cyc"}, 64'(done_q[0]), 64'(e_done));
    check({tag, "_en_cnt"}, 64'(en_q.size()), 64'(ee.size()));
    for (int i = 0; i < en_q.size() && i < ee.size(); i++)
      check($sformatf("%s_en%0d", tag, i), en_q[i], ee[i]);
    check({tag, "_pix_cnt"}, 64'(pix_q.size()), 64'(ep.size()));
    for (int i = 0; i < pix_q.size() && i < ep.size(); i++)
      check($sformatf("%s_pix%0d", tag, i), pix_q[i], ep[i]);
    check({tag, "_err"}, 64'(bus.timeout_err), 64'(e_err));
    check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    bus.frame_go  = 1'b0;
    bus.skip_mask = '0;
    repeat (3) @(negedge clock);
    check("rst_vga", {bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}, 64'd0);
    check("rst_en", 64'(bus.client_en), 64'd0);
    check("rst_flags", {bus.busy, bus.pass_done}, 64'd0);
    check("rst_err", 64'(bus.timeout_err), 64'd0);
    reset = 1'b0;

    run_pass("full", 4'b0000, 1'b1);
    run_pass("skip0101", 4'b0101, 1'b0);
    run_pass("skipall", 4'b1111, 1'b0);

    len[2] = 0;
    run_pass("hang", 4'b0000, 1'b0);
    len[2] = 3;
    run_pass("clear", 4'b1111, 1'b0);

    len[0] = 16;
    run_pass("fin_at_limit", 4'b1110, 1'b0);
    len[0] = 17;
    run_pass("over_limit", 4'b1110, 1'b0);
    len[0] = 3;

    stray[3] = 1'b1;
    run_pass("stray", 4'b1101, 1'b0);
    stray[3] = 1'b0;

    len[0] = 4;
    px_x[0][0] = 8'd170; px_y[0][0] = 7'd10;
    px_x[0][1] = 8'd133; px_y[0][1] = 7'd102;
    px_x[0][2] = 8'd160; px_y[0][2] = 7'd5;
    px_x[0][3] = 8'd159; px_y[0][3] = 7'd119;
    run_pass("clip", 4'b1110, 1'b0);
    default_pixels();

    // Reset during client 1's first RUN cycle abandons the pass.
    pix_q.delete(); en_q.delete(); done_q.delete();
    @(posedge clock);
    #1;
    bus.skip_mask = '0;
    bus.frame_go  = 1'b1;
    @(posedge clock);
    #1;
    bus.frame_go = 1'b0;
    repeat (6) @(negedge clock);
    check("mid_en1", 64'(bus.client_en), 64'b0010);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_vga", {bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}, 64'd0);
    check("mid_flags", {bus.client_en, bus.busy, bus.pass_done}, 64'd0);
    check("mid_err", 64'(bus.timeout_err), 64'd0);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check("mid_no_done", 64'(done_q.size()), 64'd0);
    check("mid_idle", 64'(bus.busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
